// File: rtl/mandelbrot_pixel_scheduler.sv
// mandelbrot_pixel_scheduler
//
// Upstream feeder for one mandelbrot_iterator lane. It walks the screen raster
// and presents the pixel index plus its complex coordinate (signed 4.23). The
// presented pixel is consumed on every rising edge where ready is high. Lanes
// split columns: this lane serves the columns x where x % NUM_LANES == LANE_ID.
//
// Ports
//   clk, reset_n        clock and asynchronous active-low reset
//   start               one-cycle frame start request (IDLE/DONE only)
//   x_origin, y_origin  coordinate of pixel (0,0), signed 4.23
//   dx, dy              per-column / per-row step, signed 4.23
//   ready               iterator accepts the presented pixel this edge
//   pix_x, pix_y        presented pixel index (10'h3FF sentinel outside RUN)
//   X, Y                presented coordinate (sentinel X=3.0, Y=0)
//   pix_valid           presented pixel is real
//   busy, done          frame in progress / frame finished
//   frame_cycles        INIT+RUN clock count of the current or last frame
module mandelbrot_pixel_scheduler #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned NUM_LANES = 1,
  parameter int unsigned LANE_ID   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [26:0] x_origin,
  input  logic [26:0] y_origin,
  input  logic [26:0] dx,
  input  logic [26:0] dy,
  input  logic        ready,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [26:0] X,
  output logic [26:0] Y,
  output logic        pix_valid,
  output logic        busy,
  output logic        done,
  output logic [31:0] frame_cycles
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  // Sentinel pixel: off-screen index and a point that escapes immediately.
  localparam logic [9:0]  SentinelPix = 10'h3FF;
  localparam logic [26:0] SentinelX   = 27'h1800000;

  state_e      state_q, state_d;
  logic [26:0] x_org_q, x_org_d;
  logic [26:0] y_org_q, y_org_d;
  logic [26:0] dx_q, dx_d;
  logic [26:0] dy_q, dy_d;
  logic [26:0] x_lane_q, x_lane_d;
  logic [26:0] stride_q, stride_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [26:0] x_q, x_d;
  logic [26:0] y_q, y_d;
  logic [31:0] frame_cycles_q, frame_cycles_d;

  logic [26:0] lane_x;
  logic [31:0] next_col;
  logic        row_end;
  logic        last_row;

  // Products keep only the low 27 bits, matching wrap-around add semantics.
  assign lane_x   = x_org_q + 27'(LANE_ID) * dx_q;
  assign next_col = 32'(pix_x_q) + 32'(NUM_LANES);
  assign row_end  = (next_col >= 32'(H_RES));
  assign last_row = (pix_y_q == 10'(V_RES - 1));

  always_comb begin
    state_d        = state_q;
    x_org_d        = x_org_q;
    y_org_d        = y_org_q;
    dx_d           = dx_q;
    dy_d           = dy_q;
    x_lane_d       = x_lane_q;
    stride_d       = stride_q;
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    x_d            = x_q;
    y_d            = y_q;
    frame_cycles_d = frame_cycles_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          x_org_d        = x_origin;
          y_org_d        = y_origin;
          dx_d           = dx;
          dy_d           = dy;
          frame_cycles_d = '0;
          state_d        = StInit;
        end
      end
      StInit: begin
        x_lane_d       = lane_x;
        stride_d       = 27'(NUM_LANES) * dx_q;
        x_d            = lane_x;
        y_d            = y_org_q;
        pix_x_d        = 10'(LANE_ID);
        pix_y_d        = '0;
        frame_cycles_d = frame_cycles_q + 32'd1;
        state_d        = StRun;
      end
      StRun: begin
        frame_cycles_d = frame_cycles_q + 32'd1;
        if (ready) begin
          if (row_end && last_row) begin
            pix_x_d = SentinelPix;
            pix_y_d = SentinelPix;
            x_d     = SentinelX;
            y_d     = '0;
            state_d = StDone;
          end else if (row_end) begin
            pix_x_d = 10'(LANE_ID);
            x_d     = x_lane_q;
            pix_y_d = pix_y_q + 10'd1;
            y_d     = y_q + dy_q;
          end else begin
            pix_x_d = 10'(next_col);
            x_d     = x_q + stride_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      x_org_q        <= '0;
      y_org_q        <= '0;
      dx_q           <= '0;
      dy_q           <= '0;
      x_lane_q       <= '0;
      stride_q       <= '0;
      pix_x_q        <= SentinelPix;
      pix_y_q        <= SentinelPix;
      x_q            <= SentinelX;
      y_q            <= '0;
      frame_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      x_org_q        <= x_org_d;
      y_org_q        <= y_org_d;
      dx_q           <= dx_d;
      dy_q           <= dy_d;
      x_lane_q       <= x_lane_d;
      stride_q       <= stride_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      x_q            <= x_d;
      y_q            <= y_d;
      frame_cycles_q <= frame_cycles_d;
    end
  end

  // Pixel registers already hold the sentinel whenever the state is not RUN.
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign X            = x_q;
  assign Y            = y_q;
  assign pix_valid    = (state_q == StRun);
  assign busy         = (state_q == StInit) || (state_q == StRun);
  assign done         = (state_q == StDone);
  assign frame_cycles = frame_cycles_q;

endmodule

// File: doc/mandelbrot_pixel_scheduler.md
Name: mandelbrot_pixel_scheduler

Overview:
- Upstream feeder for one mandelbrot_iterator lane.
- Walks the screen raster and presents pixel index (pix_x, pix_y) plus complex coordinate (X, Y, signed 4.23) to the iterator.
- Advances on every clock where the iterator's ready is high.
- LANE_ID/NUM_LANES partition columns so several scheduler+iterator pairs render one frame in parallel; a per-frame cycle counter supports render-time display.

Parameters:
- H_RES, 640, screen width in pixels.
- V_RES, 480, screen height in pixels.
- NUM_LANES, 1, number of parallel lanes (1..H_RES); this lane serves columns x with x % NUM_LANES == LANE_ID.
- LANE_ID, 0, this lane's index (0..NUM_LANES-1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start request.
- x_origin  in  27  signed 4.23; real coordinate of column 0.
- y_origin  in  27  signed 4.23; imaginary coordinate of row 0.
- dx  in  27  signed 4.23; per-column step.
- dy  in  27  signed 4.23; per-row step.
- ready  in  1  iterator ready; the presented pixel is consumed on every rising edge where ready=1.
- pix_x  out  10  column of the presented pixel.
- pix_y  out  10  row of the presented pixel.
- X  out  27  signed 4.23 real coordinate.
- Y  out  27  signed 4.23 imaginary coordinate.
- pix_valid  out  1  presented pixel is real, not a sentinel.
- busy  out  1  high in INIT/RUN.
- done  out  1  high in DONE until the next accepted start.
- frame_cycles  out  32  clocks spent in INIT+RUN for the last or current frame.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (reset_n), clocked on clk. All state clears immediately on reset_n=0, including mid-frame; no partial-frame resume.
- Reset/sentinel values:
  - pix_x=pix_y=10'h3FF, X=3<<23 (25165824), Y=0.
  - pix_valid=0, busy=0, done=0, frame_cycles=0.
  - The sentinel escapes on the first iteration; downstream drops it because pix_x>=H_RES.
  - The sentinel is driven in every state except RUN.
- States IDLE, INIT, RUN, DONE; encoding free.
  - IDLE: start=1 -> INIT. Latch x_origin/y_origin/dx/dy; clear frame_cycles.
  - INIT (exactly 1 cycle):
    - x_lane = x_origin + LANE_ID*dx
    - stride = NUM_LANES*dx (low 27 bits kept)
    - X=x_lane, Y=y_origin, pix_x=LANE_ID, pix_y=0.
    - -> RUN.
  - RUN: pix_valid=1. On each edge with ready=1 the current pixel is consumed, then:
    - Last pixel of the lane (pix_x+NUM_LANES>=H_RES and pix_y==V_RES-1): -> DONE, sentinel driven next cycle.
    - Else if pix_x+NUM_LANES>=H_RES: pix_x=LANE_ID, X=x_lane, pix_y+=1, Y+=dy.
    - Else: pix_x+=NUM_LANES, X+=stride.
    - ready=0: all outputs hold.
  - DONE: done=1, busy=0. start=1 -> INIT with the same latching as IDLE (done drops the next cycle).
- start in INIT/RUN is ignored; input changes are not sampled after latching.
- Arithmetic: 27-bit two's-complement adds, wrap on overflow (no saturation); the iterator's range checks handle out-of-range values.
- Throughput: one pixel per cycle while ready is held high; zero-cycle response to ready (outputs are registers updated on the consuming edge).
- frame_cycles: +1 every cycle in INIT or RUN; holds in IDLE/DONE; wraps at 2^32.
- Pixels per lane per frame = ceil((H_RES-LANE_ID)/NUM_LANES)*V_RES; exactly that many valid consumptions occur.
- Simultaneous: ready=1 on the last pixel in the same cycle start=1 -> start ignored, DONE entered.

Test Plan:
- H_RES=4, V_RES=2, NUM_LANES=1; x_origin=-2<<23, y_origin=1<<23, dx=1<<22, dy=-(1<<22); ready tied 1; pulse start -> 8 consecutive valid pixels (0,0)..(3,1).
  - X sequence -16777216, -12582912, -8388608, -4194304, repeating per row.
  - Y = 8388608 then 4194304.
  - done=1 the cycle after (3,1); frame_cycles=9.
- Same setup, ready toggled 1,0,0,1,...: outputs hold during ready=0; still exactly 8 valid consumptions; frame_cycles grows by the stall count.
- NUM_LANES=3, LANE_ID=1, H_RES=8, V_RES=1: columns 1, 4, 7 only; X steps by 3*dx; 3 valid pixels, then sentinel pix_x=1023, X=25165824.
- reset_n low mid-RUN (after 3 pixels) -> outputs return to sentinel/zero values asynchronously; start after release begins at (LANE_ID,0).
- start pulsed during RUN ignored (pixel count unchanged); start in DONE restarts with newly latched origin, done drops, frame_cycles restarts from 0.
- Wrap: x_origin=27'h3FFFFFF (max positive), dx=1 -> second X=-67108864 (two's-complement wrap), no hang.
